pwm_motor_drive: RTL

PWM_MOTOR_DRIVE -- requirements
Module: pwm_motor_drive

---
 rtl/motor_pkg.sv | 18 +
 rtl/motor_ch.sv | 142 ++++++++++++++
 rtl/pwm_motor_drive.sv | 67 ++++++
 3 files changed

// File: rtl/motor_pkg.sv
// Shared types and default parameters for the PWM motor drive.
package motor_pkg;

    // Per-channel drive state.
    typedef enum logic [1:0] {
        ST_ZERO = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_DEAD = 2'd3
    } ch_state_e;

    localparam int unsigned DEF_NUM_CH    = 2;
    localparam int unsigned DEF_CMD_W     = 11;
    localparam int unsigned DEF_RAMP_STEP = 16;
    localparam int unsigned DEF_RAMP_DIV  = 1024;
    localparam int unsigned DEF_DEAD_CYC  = 64;

endpackage

// File: rtl/motor_ch.sv
// One motor channel: target capture, slew-limited speed ramp, direction FSM
// with dead time on reversal, and registered PWM/brake outputs.
//   clk, rst_n   clock, async active-low reset
//   cmd          signed speed command lane
//   cmd_vld      capture strobe for cmd
//   brake_mode   1 = brake (both high) at zero speed, 0 = coast (both low)
//   tick         shared ramp tick
//   pwm_cnt      shared free-running PWM counter
//   fwd, rev     registered bridge drives
//   at_target    registered: applied == target and not in dead time
module motor_ch
    import motor_pkg::*;
#(
    parameter int unsigned CMD_W     = DEF_CMD_W,
    parameter int unsigned RAMP_STEP = DEF_RAMP_STEP,
    parameter int unsigned DEAD_CYC  = DEF_DEAD_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CMD_W-1:0] cmd,
    input  logic             cmd_vld,
    input  logic             brake_mode,
    input  logic             tick,
    input  logic [CMD_W-2:0] pwm_cnt,
    output logic             fwd,
    output logic             rev,
    output logic             at_target
);

    localparam int unsigned MW  = CMD_W - 1;
    localparam int unsigned XW  = CMD_W + 1;
    localparam int unsigned DCW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

    localparam logic [CMD_W-1:0] MOST_NEG = {1'b1, {MW{1'b0}}};
    localparam logic [CMD_W-1:0] NEG_FULL = MOST_NEG + CMD_W'(1);

    ch_state_e        state, state_n;
    logic [CMD_W-1:0] target, applied, applied_n;
    logic [DCW-1:0]   dead_cnt, dead_cnt_n;
    logic [CMD_W-1:0] cmd_sat_c;

    logic             app_pos, app_neg, tgt_pos, tgt_neg, opp_c;
    logic [XW-1:0]    goal_x, app_x, diff_x, mag_x;
    logic [CMD_W-1:0] step_c, ramp_val_c, app_mag_c;
    logic             pwm_c, fwd_c, rev_c, at_target_c;

    // Most-negative code has no positive counterpart; clamp it.
    assign cmd_sat_c = (cmd == MOST_NEG) ? NEG_FULL : cmd;

    // One ramp step toward the goal; goal is 0 while the target sign opposes applied.
    always_comb begin
        app_pos    = !applied[CMD_W-1] && (applied != '0);
        app_neg    = applied[CMD_W-1];
        tgt_pos    = !target[CMD_W-1] && (target != '0);
        tgt_neg    = target[CMD_W-1];
        opp_c      = (app_pos && tgt_neg) || (app_neg && tgt_pos);
        app_x      = {applied[CMD_W-1], applied};
        goal_x     = opp_c ? '0 : {target[CMD_W-1], target};
        diff_x     = goal_x - app_x;
        mag_x      = diff_x[XW-1] ? (XW'(0) - diff_x) : diff_x;
        step_c     = (mag_x > XW'(RAMP_STEP)) ? CMD_W'(RAMP_STEP) : mag_x[CMD_W-1:0];
        ramp_val_c = diff_x[XW-1] ? (applied - step_c) : (applied + step_c);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_ZERO;
            applied  <= '0;
            target   <= '0;
            dead_cnt <= '0;
        end else begin
            state    <= state_n;
            applied  <= applied_n;
            dead_cnt <= dead_cnt_n;
            if (cmd_vld) begin
                target <= cmd_sat_c;
            end
        end
    end

    // Next-state logic; dead time runs on clk cycles and ignores ticks.
    always_comb begin
        state_n    = state;
        applied_n  = applied;
        dead_cnt_n = dead_cnt;
        case (state)
            ST_DEAD: begin
                if (dead_cnt == '0) begin
                    state_n = ST_ZERO;
                end else begin
                    dead_cnt_n = dead_cnt - DCW'(1);
                end
            end
            default: begin
                if (tick) begin
                    applied_n = ramp_val_c;
                    if (ramp_val_c == '0) begin
                        state_n    = opp_c ? ST_DEAD : ST_ZERO;
                        dead_cnt_n = DCW'(DEAD_CYC - 1);
                    end else begin
                        state_n = ramp_val_c[CMD_W-1] ? ST_REV : ST_FWD;
                    end
                end
            end
        endcase
    end

    // Output decode; only one leg ever carries PWM.
    always_comb begin
        app_mag_c   = applied[CMD_W-1] ? (CMD_W'(0) - applied) : applied;
        pwm_c       = {1'b0, pwm_cnt} < app_mag_c;
        fwd_c       = brake_mode;
        rev_c       = brake_mode;
        at_target_c = (applied == target) && (state != ST_DEAD);
        case (state)
            ST_FWD: begin
                fwd_c = pwm_c;
                rev_c = 1'b0;
            end
            ST_REV: begin
                fwd_c = 1'b0;
                rev_c = pwm_c;
            end
            default: ;
        endcase
    end

    // Output register; reset forces the bridge off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd       <= 1'b0;
            rev       <= 1'b0;
            at_target <= 1'b1;
        end else begin
            fwd       <= fwd_c;
            rev       <= rev_c;
            at_target <= at_target_c;
        end
    end

endmodule

// File: rtl/pwm_motor_drive.sv
// Multi-channel PWM motor drive: shared ramp prescaler and PWM counter,
// one motor_ch per channel.
//   clk, rst_n   clock, async active-low reset
//   cmd          NUM_CH packed signed speed commands (lane i at [i*CMD_W +: CMD_W])
//   cmd_vld      capture strobe for all lanes
//   brake_mode   zero-speed drive style
//   fwd, rev     per-channel registered bridge drives
//   at_target    per-channel registered settle flag
module pwm_motor_drive
    import motor_pkg::*;
#(
    parameter int unsigned NUM_CH    = DEF_NUM_CH,
    parameter int unsigned CMD_W     = DEF_CMD_W,
    parameter int unsigned RAMP_STEP = DEF_RAMP_STEP,
    parameter int unsigned RAMP_DIV  = DEF_RAMP_DIV,
    parameter int unsigned DEAD_CYC  = DEF_DEAD_CYC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*CMD_W-1:0] cmd,
    input  logic                    cmd_vld,
    input  logic                    brake_mode,
    output logic [NUM_CH-1:0]       fwd,
    output logic [NUM_CH-1:0]       rev,
    output logic [NUM_CH-1:0]       at_target
);

    localparam int unsigned PSW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned MW  = CMD_W - 1;

    logic [PSW-1:0] presc;
    logic [MW-1:0]  pwm_cnt;
    logic           tick_c;

    assign tick_c = (presc == PSW'(RAMP_DIV - 1));

    // Ramp prescaler and PWM carrier counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= '0;
            pwm_cnt <= '0;
        end else begin
            presc   <= tick_c ? '0 : presc + PSW'(1);
            pwm_cnt <= pwm_cnt + MW'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        motor_ch #(
            .CMD_W     (CMD_W),
            .RAMP_STEP (RAMP_STEP),
            .DEAD_CYC  (DEAD_CYC)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .cmd        (cmd[i*CMD_W +: CMD_W]),
            .cmd_vld    (cmd_vld),
            .brake_mode (brake_mode),
            .tick       (tick_c),
            .pwm_cnt    (pwm_cnt),
            .fwd        (fwd[i]),
            .rev        (rev[i]),
            .at_target  (at_target[i])
        );
    end

endmodule
